// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: StallBus type, stall vector constants, sequencer states
// and the request priority encoder shared by the pipeline controller.
package pipe_ctrl_pkg;
    typedef logic [5:0] stall_bus_t;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam stall_bus_t STALL_NONE   = 6'b000000;
    localparam stall_bus_t STALL_ID     = 6'b000111;
    localparam stall_bus_t STALL_EX     = 6'b001111;
    localparam stall_bus_t STALL_MEM    = 6'b011111;
    localparam stall_bus_t STALL_REFILL = 6'b000011;
    typedef enum logic [1:0] {RUN, PEND, FLUSH, REFILL} state_t;
    // Later stages win: freezing more of the pipe subsumes a shorter freeze.
    function automatic stall_bus_t stall_encode(input logic mem, input logic ex, input logic id);
        return mem ? STALL_MEM : ex ? STALL_EX : id ? STALL_ID : STALL_NONE;
    endfunction
endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles and raises a sticky
// flag once TIMEOUT is reached; only rst clears the flag.
module stall_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic timeout
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    logic         flag_q, flag_d;
    always_comb begin
        cnt_d  = clear ? '0 : (run && cnt_q != W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
        flag_d = flag_q | (cnt_d == W'(TIMEOUT));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end
    assign timeout = flag_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges ID/EX/MEM stall requests into the StallBus, sequences
// exception flush plus refill bubble, and tracks stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_WD  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              excp_req,
    input  logic [31:0]       excp_target,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              stall_timeout,
    output logic [CNT_WD-1:0] stall_cnt
);
    state_t            state_q, state_d;
    logic [31:0]       target_q, target_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    stall_bus_t        stall_s;
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        stall_s  = STALL_NONE;
        case (state_q)
            RUN: begin
                stall_s = stall_encode(stallreq_mem, stallreq_ex, stallreq_id);
                if (excp_req) begin
                    target_d = excp_target;
                    state_d  = stallreq_mem ? PEND : FLUSH;
                end
            end
            PEND: begin
                stall_s = STALL_MEM;
                state_d = stallreq_mem ? PEND : FLUSH;
            end
            FLUSH:   state_d = REFILL;
            REFILL: begin
                stall_s = STALL_REFILL;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // new_pc only moves on entry to FLUSH so it holds the last redirect.
        new_pc_d = (state_d == FLUSH) ? target_d : new_pc_q;
        stall    = rst ? STALL_NONE : stall_s;
        cnt_d    = (stall[0] && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            target_q <= '0;
            new_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
        end
    end
    stall_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .run     ((state_q == RUN || state_q == PEND) && stall != STALL_NONE),
        .clear   (stall == STALL_NONE),
        .timeout (stall_timeout)
    );
    assign flush     = (state_q == FLUSH);
    assign new_pc    = new_pc_q;
    assign stall_cnt = cnt_q;
endmodule
